mac_tx_framer: RTL and testbench

MAC_TX_FRAMER -- requirements
Module: mac_tx_framer

---
 rtl/mac_tx_pkg.sv | 37 +++
 rtl/mac_tx_framer_crc32_d8.sv | 30 +++
 rtl/mac_tx_framer.sv | 187 ++++++++++++++++++
 tb/tb_mac_tx_framer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_tx_pkg
// Description : Shared types and constants for the GMII transmit framer.
// Revision    : 1.0  initial release
// ============================================================================
package mac_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_DRAIN    = 3'd6,
        ST_IPG      = 3'd7
    } tx_state_t;

    typedef logic [10:0] byte_cnt_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    localparam int          c_preamble_len = 7;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i] = v[31 - i];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_tx_framer_crc32_d8.sv
`default_nettype none
// ============================================================================
// Module      : crc32_d8
// Description : Combinational Ethernet CRC-32 step, one byte per call,
//               operating on the reflected (LSB-first) register form.
// Revision    : 1.0  initial release
// ============================================================================
module crc32_d8
    import mac_tx_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    localparam logic [31:0] c_poly_refl = reflect32(CRC_POLY);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = i_crc ^ {24'd0, i_data};
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ c_poly_refl) : (w_crc >> 1);
        end
    end

    assign o_crc = w_crc;

endmodule
`default_nettype wire

// File: rtl/mac_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : mac_tx_framer
// Description : GMII transmit framer: preamble/SFD, padding, FCS, IPG and
//               underrun/oversize abort. The state register leads the
//               registered outputs by one byte time.
// Revision    : 1.0  initial release
// ============================================================================
module mac_tx_framer
    import mac_tx_pkg::*;
#(
    parameter int IPG_BYTES = 12,
    parameter int MIN_DATA  = 60,
    parameter int MAX_DATA  = 1514
) (
    input  logic       mac_clk_tx,
    input  logic       reset_tx,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] txd_out,
    output logic       txen_out,
    output logic       txer_out,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [15:0] c_preamble_last = 16'(c_preamble_len - 1);
    localparam logic [15:0] c_ipg_last      = 16'(IPG_BYTES - 1);
    localparam byte_cnt_t   c_min_data      = byte_cnt_t'(MIN_DATA);
    localparam byte_cnt_t   c_max_data      = byte_cnt_t'(MAX_DATA);

    tx_state_t   r_state, w_state;
    logic [15:0] r_aux_cnt, w_aux_cnt;
    byte_cnt_t   r_byte_cnt, w_byte_cnt, w_cnt_inc;
    logic [31:0] r_crc, w_crc, w_crc_next, w_fcs;
    logic [7:0]  r_txd, w_txd, w_crc_din;
    logic        r_txen, w_txen;
    logic        r_txer, w_txer;
    logic        r_in_ready, w_in_ready;
    logic        r_frame_done, w_frame_done;
    logic        r_underrun, w_underrun;

    assign w_crc_din = (r_state == ST_PAD) ? 8'h00 : in_data;
    assign w_cnt_inc = (r_byte_cnt == '1) ? r_byte_cnt : r_byte_cnt + byte_cnt_t'(1);
    assign w_fcs     = ~r_crc;

    crc32_d8 u_crc32_d8 (
        .i_crc  (r_crc),
        .i_data (w_crc_din),
        .o_crc  (w_crc_next)
    );

    always_ff @(posedge mac_clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            r_state      <= ST_IDLE;
            r_aux_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_crc        <= CRC_INIT;
            r_txd        <= 8'h00;
            r_txen       <= 1'b0;
            r_txer       <= 1'b0;
            r_in_ready   <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_aux_cnt    <= w_aux_cnt;
            r_byte_cnt   <= w_byte_cnt;
            r_crc        <= w_crc;
            r_txd        <= w_txd;
            r_txen       <= w_txen;
            r_txer       <= w_txer;
            r_in_ready   <= w_in_ready;
            r_frame_done <= w_frame_done;
            r_underrun   <= w_underrun;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_aux_cnt    = r_aux_cnt;
        w_byte_cnt   = r_byte_cnt;
        w_crc        = r_crc;
        w_txd        = 8'h00;
        w_txen       = 1'b0;
        w_txer       = 1'b0;
        w_in_ready   = 1'b0;
        w_frame_done = 1'b0;
        w_underrun   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state   = ST_PREAMBLE;
                    w_txd     = PREAMBLE_BYTE;
                    w_txen    = 1'b1;
                    w_aux_cnt = 16'd1;
                end
            end
            ST_PREAMBLE: begin
                w_txd     = PREAMBLE_BYTE;
                w_txen    = 1'b1;
                w_aux_cnt = r_aux_cnt + 16'd1;
                if (r_aux_cnt == c_preamble_last) w_state = ST_SFD;
            end
            ST_SFD: begin
                // Ready rises while SFD is on the wire so data follows with no bubble.
                w_txd      = SFD_BYTE;
                w_txen     = 1'b1;
                w_in_ready = 1'b1;
                w_byte_cnt = '0;
                w_crc      = CRC_INIT;
                w_state    = ST_DATA;
            end
            ST_DATA: begin
                w_txen = 1'b1;
                if ((r_byte_cnt == c_max_data) || !in_valid) begin
                    w_txer     = 1'b1;
                    w_underrun = 1'b1;
                    w_in_ready = 1'b1;
                    w_state    = ST_DRAIN;
                    // An oversize frame whose terminating byte lands on the abort cycle has nothing left to drain.
                    if (in_valid && in_last) begin
                        w_in_ready = 1'b0;
                        w_state    = ST_IPG;
                        w_aux_cnt  = '0;
                    end
                end else begin
                    w_txd      = in_data;
                    w_crc      = w_crc_next;
                    w_byte_cnt = w_cnt_inc;
                    if (in_last) begin
                        w_state   = (w_cnt_inc < c_min_data) ? ST_PAD : ST_FCS;
                        w_aux_cnt = '0;
                    end else begin
                        w_in_ready = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                w_txen     = 1'b1;
                w_crc      = w_crc_next;
                w_byte_cnt = w_cnt_inc;
                if (w_cnt_inc >= c_min_data) begin
                    w_state   = ST_FCS;
                    w_aux_cnt = '0;
                end
            end
            ST_FCS: begin
                w_txen    = 1'b1;
                w_txd     = w_fcs[{r_aux_cnt[1:0], 3'b000} +: 8];
                w_aux_cnt = r_aux_cnt + 16'd1;
                if (r_aux_cnt[1:0] == 2'd3) begin
                    w_frame_done = 1'b1;
                    w_state      = ST_IPG;
                    w_aux_cnt    = '0;
                end
            end
            ST_DRAIN: begin
                w_in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_in_ready = 1'b0;
                    w_state    = ST_IPG;
                    w_aux_cnt  = '0;
                end
            end
            ST_IPG: begin
                w_aux_cnt = r_aux_cnt + 16'd1;
                if (r_aux_cnt == c_ipg_last) w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign in_ready   = r_in_ready;
    assign txd_out    = r_txd;
    assign txen_out   = r_txen;
    assign txer_out   = r_txer;
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mac_tx_framer
// Description : Self-checking bench for mac_tx_framer (table, random, corners).
// Revision    : 1.0  initial release
// ============================================================================
module tb_mac_tx_framer;
    import mac_tx_pkg::*;

    localparam int IPG = 12;
    localparam int MIN = 60;
    localparam int MAX = 1514;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        int len;
        int pat;
        int exp_txen;
        int exp_done;
        int exp_under;
    } vec_t;

    logic       mac_clk_tx = 1'b0;
    logic       reset_tx   = 1'b1;
    logic [7:0] in_data    = 8'h00;
    logic       in_valid   = 1'b0;
    logic       in_last    = 1'b0;
    logic       in_ready;
    logic [7:0] txd_out;
    logic       txen_out;
    logic       txer_out;
    logic       frame_done;
    logic       underrun;

    int passed = 0;
    int total  = 0;

    mac_tx_framer #(.IPG_BYTES(IPG), .MIN_DATA(MIN), .MAX_DATA(MAX)) dut (
        .mac_clk_tx (mac_clk_tx),
        .reset_tx   (reset_tx),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .txd_out    (txd_out),
        .txen_out   (txen_out),
        .txer_out   (txer_out),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 mac_clk_tx = ~mac_clk_tx;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- output monitor ----------------
    byte_q_t cur_q, burst_q;
    int len_hist[$];
    int gap_hist[$];
    int bursts = 0, low_run = 0, txer_cnt = 0, txer_pos = 0;
    int done_cnt = 0, done_pos = 0, under_cnt = 0, idle_bad = 0, ready_bad = 0;

    always @(negedge mac_clk_tx) begin
        if (reset_tx) begin
            cur_q.delete();
            low_run = 0;
        end else begin
            if (txen_out) begin
                if (cur_q.size() == 0) gap_hist.push_back(low_run);
                cur_q.push_back(txd_out);
                low_run = 0;
                if (in_ready && cur_q.size() < 8) ready_bad++;
            end else begin
                if (cur_q.size() != 0) begin
                    burst_q = cur_q;
                    len_hist.push_back(cur_q.size());
                    cur_q.delete();
                    bursts++;
                end
                low_run++;
                if (txd_out != 8'h00) idle_bad++;
            end
            if (txer_out) begin
                txer_cnt++;
                txer_pos = cur_q.size();
            end
            if (frame_done) begin
                done_cnt++;
                done_pos = cur_q.size();
            end
            if (underrun) under_cnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [31:0] crc_norm(input byte_q_t p);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFFFFFF;
        foreach (p[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[31] ^ p[i][b];
                c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
            end
        end
        return c;
    endfunction

    function automatic byte_q_t expect_frame(input byte_q_t d);
        byte_q_t e, p;
        logic [31:0] c, fcs;
        p = d;
        while (p.size() < MIN) p.push_back(8'h00);
        c = crc_norm(p);
        for (int i = 0; i < 32; i++) fcs[i] = ~c[31 - i];
        for (int i = 0; i < 7; i++) e.push_back(8'h55);
        e.push_back(8'hD5);
        foreach (p[i]) e.push_back(p[i]);
        for (int i = 0; i < 4; i++) e.push_back(fcs[8*i +: 8]);
        return e;
    endfunction

    function automatic byte_q_t make_data(input int len, input int pat);
        byte_q_t d;
        for (int i = 0; i < len; i++) begin
            case (pat)
                0:       d.push_back(i[7:0]);
                1:       d.push_back(8'hAA);
                default: d.push_back(8'($urandom));
            endcase
        end
        return d;
    endfunction

    int  hs_count = 0;
    bit  abort    = 0;

    task automatic drive_frame(input byte_q_t d, input int gap_after, input bit keep_valid, output bit ok);
        int i = 0;
        int guard = 0;
        bit hs;
        bit gapped = 0;
        ok = 1;
        while (i < d.size() && !abort) begin
            @(negedge mac_clk_tx);
            if (gap_after >= 0 && i == gap_after && !gapped) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = 8'h00;
                gapped   = 1;
                @(posedge mac_clk_tx);
            end else begin
                in_valid = 1'b1;
                in_data  = d[i];
                in_last  = (i == d.size() - 1);
                hs       = in_ready;
                @(posedge mac_clk_tx);
                if (hs) begin
                    i++;
                    hs_count++;
                    guard = 0;
                end else if (++guard > 4000) begin
                    ok = 0;
                    break;
                end
            end
        end
        if (!keep_valid) begin
            @(negedge mac_clk_tx);
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = 8'h00;
        end
    endtask

    task automatic wait_bursts(input int target, input string tag);
        int n = 0;
        while (bursts < target && n < 5000) begin
            @(negedge mac_clk_tx);
            n++;
        end
        check($sformatf("%s burst timeout", tag), (bursts >= target) ? 1 : 0, 1);
    endtask

    task automatic check_stream(input string tag, input byte_q_t exp);
        int bad = 0;
        check($sformatf("%s length", tag), burst_q.size(), exp.size());
        foreach (exp[i]) if (i >= burst_q.size() || burst_q[i] !== exp[i]) bad++;
        check($sformatf("%s byte errors", tag), bad, 0);
    endtask

    task automatic check_residue(input string tag);
        byte_q_t p;
        for (int i = 8; i < burst_q.size(); i++) p.push_back(burst_q[i]);
        check($sformatf("%s crc residue", tag), crc_norm(p), CRC_RESIDUE);
    endtask

    // ---------------- test sequence ----------------
    vec_t    tbl [6];
    byte_q_t d, d2, e;
    bit      ok, ok2;
    int      pb, pd, pu, pt;

    initial begin
        tbl[0] = '{len: 60,   pat: 0, exp_txen: 72,   exp_done: 1, exp_under: 0};
        tbl[1] = '{len: 1,    pat: 1, exp_txen: 72,   exp_done: 1, exp_under: 0};
        tbl[2] = '{len: 59,   pat: 2, exp_txen: 72,   exp_done: 1, exp_under: 0};
        tbl[3] = '{len: 61,   pat: 2, exp_txen: 73,   exp_done: 1, exp_under: 0};
        tbl[4] = '{len: 100,  pat: 0, exp_txen: 112,  exp_done: 1, exp_under: 0};
        tbl[5] = '{len: 1514, pat: 2, exp_txen: 1526, exp_done: 1, exp_under: 0};

        repeat (3) @(negedge mac_clk_tx);
        check("reset txd_out", txd_out, 0);
        check("reset txen_out", txen_out, 0);
        check("reset txer_out", txer_out, 0);
        check("reset in_ready", in_ready, 0);
        check("reset frame_done", frame_done, 0);
        check("reset underrun", underrun, 0);
        reset_tx = 1'b0;
        repeat (3) @(negedge mac_clk_tx);

        for (int k = 0; k < 6; k++) begin
            d  = make_data(tbl[k].len, tbl[k].pat);
            e  = expect_frame(d);
            pb = bursts; pd = done_cnt; pu = under_cnt;
            drive_frame(d, -1, 0, ok);
            check($sformatf("tbl%0d drive", k), ok, 1);
            wait_bursts(pb + 1, $sformatf("tbl%0d", k));
            check($sformatf("tbl%0d txen cycles", k), burst_q.size(), tbl[k].exp_txen);
            check_stream($sformatf("tbl%0d", k), e);
            check($sformatf("tbl%0d frame_done", k), done_cnt - pd, tbl[k].exp_done);
            check($sformatf("tbl%0d done position", k), done_pos, burst_q.size());
            check($sformatf("tbl%0d underrun", k), under_cnt - pu, tbl[k].exp_under);
            check_residue($sformatf("tbl%0d", k));
            repeat (IPG + 4) @(negedge mac_clk_tx);
        end

        for (int k = 0; k < 6; k++) begin
            d  = make_data($urandom_range(1, 150), 2);
            e  = expect_frame(d);
            pb = bursts; pd = done_cnt;
            drive_frame(d, -1, 0, ok);
            wait_bursts(pb + 1, $sformatf("rnd%0d", k));
            check_stream($sformatf("rnd%0d len %0d", k, d.size()), e);
            check($sformatf("rnd%0d frame_done", k), done_cnt - pd, 1);
            repeat ($urandom_range(IPG, IPG + 6)) @(negedge mac_clk_tx);
        end

        // back-to-back 100-byte frames with in_valid held high
        d  = make_data(100, 2);
        d2 = make_data(100, 2);
        pb = bursts;
        drive_frame(d, -1, 1, ok);
        drive_frame(d2, -1, 0, ok2);
        wait_bursts(pb + 2, "b2b");
        check("b2b first burst", len_hist[pb], 112);
        check("b2b second burst", len_hist[pb + 1], 112);
        check("b2b ipg", gap_hist[pb + 1], IPG);
        check_stream("b2b second", expect_frame(d2));
        repeat (IPG + 4) @(negedge mac_clk_tx);

        // underrun after byte 10 of 80, followed immediately by a good frame
        d  = make_data(80, 0);
        d2 = make_data(60, 2);
        pb = bursts; pd = done_cnt; pu = under_cnt; pt = txer_cnt;
        drive_frame(d, 10, 1, ok);
        drive_frame(d2, -1, 0, ok2);
        check("und drive", ok & ok2, 1);
        wait_bursts(pb + 2, "und");
        check("und burst len", len_hist[pb], 19);
        check("und txer cycles", txer_cnt - pt, 1);
        check("und txer position", txer_pos, 19);
        check("und pulses", under_cnt - pu, 1);
        check("und drain+ipg gap", gap_hist[pb + 1], 70 + IPG);
        check("und frame_done", done_cnt - pd, 1);
        check_stream("und next frame", expect_frame(d2));
        repeat (IPG + 4) @(negedge mac_clk_tx);

        // oversize: 1600 bytes, terminator only on the last one
        d  = make_data(1600, 2);
        pb = bursts; pd = done_cnt; pu = under_cnt;
        drive_frame(d, -1, 0, ok);
        check("ovr drive", ok, 1);
        wait_bursts(pb + 1, "ovr");
        e = {};
        for (int i = 0; i < 7; i++) e.push_back(8'h55);
        e.push_back(8'hD5);
        for (int i = 0; i < MAX; i++) e.push_back(d[i]);
        e.push_back(8'h00);
        check_stream("ovr", e);
        check("ovr txer position", txer_pos, MAX + 9);
        check("ovr underrun", under_cnt - pu, 1);
        check("ovr frame_done", done_cnt - pd, 0);
        repeat (IPG + 4) @(negedge mac_clk_tx);

        // asynchronous reset in the middle of data
        d  = make_data(80, 2);
        pu = under_cnt; pt = txer_cnt; pb = bursts;
        hs_count = 0;
        abort = 0;
        fork
            drive_frame(d, -1, 0, ok);
            begin : rst_proc
                int n;
                n = 0;
                while (hs_count < 20 && n < 2000) begin
                    @(negedge mac_clk_tx);
                    n++;
                end
                check("rst reach byte 20", (hs_count >= 20) ? 1 : 0, 1);
                check("rst txen before", txen_out, 1);
                #2 reset_tx = 1'b1;
                abort = 1;
                #1;
                check("rst txen same cycle", txen_out, 0);
                check("rst in_ready same cycle", in_ready, 0);
                check("rst txer same cycle", txer_out, 0);
            end
        join
        repeat (3) @(negedge mac_clk_tx);
        reset_tx = 1'b0;
        abort = 0;
        repeat (2) @(negedge mac_clk_tx);
        check("rst no underrun", under_cnt - pu, 0);
        check("rst no txer", txer_cnt - pt, 0);
        check("rst no burst", bursts - pb, 0);
        d = make_data(60, 2);
        pd = done_cnt;
        drive_frame(d, -1, 0, ok);
        wait_bursts(pb + 1, "rst");
        check_stream("post-reset", expect_frame(d));
        check("post-reset frame_done", done_cnt - pd, 1);
        check_residue("post-reset");
        repeat (IPG + 4) @(negedge mac_clk_tx);

        check("txd nonzero while idle", idle_bad, 0);
        check("in_ready during preamble", ready_bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
